// File: rtl/mem_defs_pkg.sv
// mem_defs: shared definitions for the MIPS memory-access stage.
//   DATA_W                          data word width (byte-lane logic assumes 32)
//   SIZE_BYTE, SIZE_HALF, SIZE_WORD access size encodings (2'b11 behaves as word)
//   memState_t                      transaction FSM state encoding
package mem_defs;

    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } memState_t;

endpackage

// File: rtl/load_store_align.sv
// load_store_align: purely combinational byte-lane handling for the memory stage.
//   storeSize, storeData -> laneData  : store data replicated across byte lanes
//   loadSize, loadOffset,
//   loadSigned, rdata    -> loadData  : selected byte/half/word, sign/zero extended
module load_store_align
    import mem_defs::*;
(
    input  logic [1:0]        storeSize,
    input  logic [DATA_W-1:0] storeData,
    output logic [DATA_W-1:0] laneData,
    input  logic [1:0]        loadSize,
    input  logic [1:0]        loadOffset,
    input  logic              loadSigned,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Replicate narrow store data so that whichever lane the bridge enables sees it.
    always_comb begin
        laneData = storeData;
        case (storeSize)
            SIZE_BYTE: laneData = {4{storeData[7:0]}};
            SIZE_HALF: laneData = {2{storeData[15:0]}};
            default:   laneData = storeData;
        endcase
    end

    // Pick the addressed field out of the returned word and extend it to 32 bits.
    always_comb begin
        byteSel  = rdata[7:0];
        halfSel  = loadOffset[1] ? rdata[31:16] : rdata[15:0];
        loadData = rdata;
        case (loadOffset)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        case (loadSize)
            SIZE_BYTE: loadData = {{24{loadSigned & byteSel[7]}}, byteSel};
            SIZE_HALF: loadData = {{16{loadSigned & halfSel[15]}}, halfSel};
            default:   loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the pipelined MIPS core. Converts the M-stage load/store
// controls into a single req/addr_ok/data_ok transaction, stalls the pipe until it ends,
// and registers the aligned, extended load result.
//   clock, reset (sync, active-high)
//   MemReadM, MemWriteM, MemSizeM, MemSignedM, ALUOutM, WriteDataM : M-stage instruction
//   FlushM, StallM                                                  : hazard unit controls
//   data_req/wr/size/addr/wdata, data_addr_ok/data_ok/rdata          : SRAM-like data bus
//   ReadDataM  : registered load result      MemStallM : stall request
//   AdELM, AdESM, BadVAddrM : address errors, active only when MEM_ALIGN_CHECK_EN is defined
module mem_access_unit
    import mem_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignedM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              FlushM,
    input  logic              StallM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemStallM,
    output logic              AdELM,
    output logic              AdESM,
    output logic [ADDR_W-1:0] BadVAddrM
);

    memState_t         state, nextState;
    logic [ADDR_W-1:0] reqAddr;
    logic              reqWr;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [DATA_W-1:0] reqWdata;
    logic              killFlag;
    logic              addrErr;
    logic              access;
    logic              captureLoad;
    logic [DATA_W-1:0] laneData;
    logic [DATA_W-1:0] loadData;

    // Address-error detection; reserved size 2'b11 is checked like a word.
`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        addrErr   = (MemReadM | MemWriteM)
                  & (((MemSizeM == SIZE_HALF) & ALUOutM[0])
                  |  ((MemSizeM[1] == 1'b1) & (ALUOutM[1:0] != 2'b00)));
        AdELM     = ~reset & addrErr & MemReadM;
        AdESM     = ~reset & addrErr & MemWriteM;
        BadVAddrM = (~reset & addrErr) ? ALUOutM : '0;
    end
`else
    always_comb begin
        addrErr   = 1'b0;
        AdELM     = 1'b0;
        AdESM     = 1'b0;
        BadVAddrM = '0;
    end
`endif

    assign access = (MemReadM | MemWriteM) & ~FlushM & ~addrErr;

    // Load extraction always works from the latched request, so the result stays correct
    // even if the M-stage inputs change while the transaction drains.
    load_store_align alignUnit (
        .storeSize (MemSizeM),
        .storeData (WriteDataM),
        .laneData  (laneData),
        .loadSize  (reqSize),
        .loadOffset(reqAddr[1:0]),
        .loadSigned(reqSigned),
        .rdata     (data_rdata),
        .loadData  (loadData)
    );

    // Next-state logic and bus outputs. In IDLE the request comes straight from the M
    // inputs; in REQ it is replayed from the latched copy until the bridge accepts it.
    always_comb begin
        nextState   = state;
        data_req    = 1'b0;
        data_wr     = MemWriteM;
        data_size   = MemSizeM;
        data_addr   = ALUOutM;
        data_wdata  = laneData;
        MemStallM   = 1'b0;
        captureLoad = 1'b0;
        case (state)
            IDLE: begin
                data_req  = access;
                MemStallM = access;
                if (access) begin
                    nextState = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req   = 1'b1;
                data_wr    = reqWr;
                data_size  = reqSize;
                data_addr  = reqAddr;
                data_wdata = reqWdata;
                MemStallM  = 1'b1;
                if (data_addr_ok) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                MemStallM = 1'b1;
                if (data_data_ok) begin
                    if (killFlag | FlushM) begin
                        nextState = IDLE;
                    end else begin
                        nextState   = DONE;
                        captureLoad = ~reqWr;
                    end
                end
            end
            default: begin
                if (FlushM | ~StallM) begin
                    nextState = IDLE;
                end
            end
        endcase
        if (reset) begin
            data_req  = 1'b0;
            MemStallM = 1'b0;
        end
    end

    // State, latched request, kill flag and the load result register. The request is
    // latched whenever a transaction starts so WAIT always knows how to extract the data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            reqAddr   <= '0;
            reqWr     <= 1'b0;
            reqSize   <= 2'b00;
            reqSigned <= 1'b0;
            reqWdata  <= '0;
            killFlag  <= 1'b0;
            ReadDataM <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && access) begin
                reqAddr   <= ALUOutM;
                reqWr     <= MemWriteM;
                reqSize   <= MemSizeM;
                reqSigned <= MemSignedM;
                reqWdata  <= laneData;
            end
            if (state == WAIT && data_data_ok) begin
                killFlag <= 1'b0;
            end else if ((state == REQ || state == WAIT) && FlushM) begin
                killFlag <= 1'b1;
            end
            if (captureLoad) begin
                ReadDataM <= loadData;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit. The bench plays the bridge
// (addr_ok / data_ok timing per vector) and keeps a cycle-level expectation of the stall,
// request and load-result outputs that a compare process checks every cycle.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, MemSignedM, FlushM, StallM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [31:0] ReadDataM, BadVAddrM;
    logic        MemStallM, AdELM, AdESM;

    int          testsRun = 0;
    int          testsFailed = 0;
    bit          checkEn = 1'b0;
    logic        expReq, expStall, expAdEL, expAdES;
    logic [31:0] expRead, expBad;

    mem_access_unit dut (
        .clock       (clock),
        .reset       (reset),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .MemSizeM    (MemSizeM),
        .MemSignedM  (MemSignedM),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .FlushM      (FlushM),
        .StallM      (StallM),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .ReadDataM   (ReadDataM),
        .MemStallM   (MemStallM),
        .AdELM       (AdELM),
        .AdESM       (AdESM),
        .BadVAddrM   (BadVAddrM)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Load result as the ISA defines it: shift the addressed field down, then extend.
    function automatic logic [31:0] expectLoad(input logic [31:0] rdata,
                                               input logic [31:0] addr,
                                               input logic [1:0] size, input bit sgn);
        logic [31:0] shifted;
        int          off;
        off = int'(addr[1:0]);
        if (size == 2'b00) begin
            shifted = rdata >> (8 * off);
            return sgn ? 32'(signed'(shifted[7:0])) : {24'h0, shifted[7:0]};
        end else if (size == 2'b01) begin
            shifted = rdata >> (16 * (off / 2));
            return sgn ? 32'(signed'(shifted[15:0])) : {16'h0, shifted[15:0]};
        end
        return rdata;
    endfunction

    function automatic logic [31:0] expectLane(input logic [31:0] wdata,
                                               input logic [1:0] size);
        if (size == 2'b00) return {24'h0, wdata[7:0]} * 32'h01010101;
        if (size == 2'b01) return {16'h0, wdata[15:0]} * 32'h00010001;
        return wdata;
    endfunction

    // Per-cycle comparison of the DUT against the bench's expectation.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("data_req", {31'h0, data_req}, {31'h0, expReq});
            checkOutput("MemStallM", {31'h0, MemStallM}, {31'h0, expStall});
            checkOutput("ReadDataM", ReadDataM, expRead);
            checkOutput("AdELM", {31'h0, AdELM}, {31'h0, expAdEL});
            checkOutput("AdESM", {31'h0, AdESM}, {31'h0, expAdES});
            checkOutput("BadVAddrM", BadVAddrM, expBad);
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        FlushM       = 1'b0;
        StallM       = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        expReq       = 1'b0;
        expStall     = 1'b0;
    endtask

    // One load/store: addr_ok after addrWait waiting cycles, data_ok dataWait cycles
    // after that. Optional flush pulse in WAIT, optional StallM cycles in DONE, optional
    // spurious data_ok coinciding with addr_ok.
    task automatic applyStimulus(input bit isLoad, input logic [1:0] size, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expWdata, input logic [31:0] rdata,
                                 input int addrWait, input int dataWait,
                                 input bit flushInWait, input int doneStall,
                                 input bit earlyOk);
        int okCycle;
        okCycle    = addrWait + 1 + dataWait;
        MemReadM   = isLoad;
        MemWriteM  = !isLoad;
        MemSizeM   = size;
        MemSignedM = sgn;
        ALUOutM    = addr;
        WriteDataM = wdata;
        FlushM     = 1'b0;
        StallM     = 1'b0;
        for (int c = 0; c <= okCycle; c++) begin
            data_addr_ok = (c == addrWait);
            data_data_ok = (c == okCycle) || (earlyOk && c == addrWait);
            data_rdata   = (c == okCycle) ? rdata : ~rdata;
            if (flushInWait && c == addrWait + 1) FlushM = 1'b1;
            if (flushInWait && c == addrWait + 2) begin
                FlushM    = 1'b0;
                MemReadM  = 1'b0;
                MemWriteM = 1'b0;
            end
            expReq   = (c <= addrWait);
            expStall = 1'b1;
            @(negedge clock);
            if (c <= addrWait) begin
                checkOutput("data_addr", data_addr, addr);
                checkOutput("data_wr", {31'h0, data_wr}, {31'h0, !isLoad});
                checkOutput("data_size", {30'h0, data_size}, {30'h0, size});
                if (!isLoad) checkOutput("data_wdata", data_wdata, expWdata);
            end
            nextCycle();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        expReq       = 1'b0;
        expStall     = 1'b0;
        if (!flushInWait) begin
            if (isLoad) expRead = expectLoad(rdata, addr, size, sgn);
            StallM = 1'b1;
            for (int d = 0; d < doneStall; d++) nextCycle();
            StallM = 1'b0;
        end
        nextCycle();
        idleInputs();
        nextCycle();
    endtask

    initial begin
        reset      = 1'b1;
        MemSizeM   = 2'b10;
        MemSignedM = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        data_rdata = 32'h0;
        idleInputs();
        expRead = 32'h0;
        expAdEL = 1'b0;
        expAdES = 1'b0;
        expBad  = 32'h0;
        nextCycle();

        // In reset a misaligned load is presented: every output must stay quiet.
        MemReadM = 1'b1;
        ALUOutM  = 32'h00000102;
        checkEn  = 1'b1;
        nextCycle();
        reset = 1'b0;
        idleInputs();
        nextCycle();

        // lw, best case: stall for exactly cycles 0 and 1.
        applyStimulus(1, 2'b10, 0, 32'h00000010, 32'h0, 32'h0, 32'h8899AABB, 0, 0, 0, 0, 0);
        checkOutput("lw_result", ReadDataM, 32'h8899AABB);

        // lb signed and lhu on the same word.
        applyStimulus(1, 2'b00, 1, 32'h00000013, 32'h0, 32'h0, 32'h80112233, 0, 0, 0, 0, 0);
        checkOutput("lb_result", ReadDataM, 32'hFFFFFF80);
        applyStimulus(1, 2'b01, 0, 32'h00000012, 32'h0, 32'h0, 32'h80112233, 1, 0, 0, 0, 0);
        checkOutput("lhu_result", ReadDataM, 32'h00008011);

        // sh with addr_ok delayed 3 cycles: request held 4 cycles, lanes replicated.
        applyStimulus(0, 2'b01, 0, 32'h00000002, 32'h1234ABCD, 32'hABCDABCD, 32'h55555555,
                      3, 1, 0, 0, 0);
        checkOutput("sh_keeps_result", ReadDataM, 32'h00008011);

        // sb lanes, then a flush while waiting for data: result must be discarded.
        applyStimulus(0, 2'b00, 0, 32'h00000005, 32'h000000C3,
                      expectLane(32'h000000C3, 2'b00), 32'h0, 0, 2, 0, 0, 0);
        applyStimulus(1, 2'b10, 0, 32'h00000020, 32'h0, 32'h0, 32'hDEADBEEF, 1, 2, 1, 0, 0);
        checkOutput("flush_discard", ReadDataM, 32'h00008011);

        // lh signed, then DONE held by StallM for 3 cycles without a second request.
        applyStimulus(1, 2'b01, 1, 32'h00000016, 32'h0, 32'h0, 32'hF00DCAFE, 0, 1, 0, 3, 0);
        checkOutput("lh_done_stall", ReadDataM, 32'hFFFFF00D);

        // data_ok coinciding with addr_ok is not a completion.
        applyStimulus(1, 2'b00, 0, 32'h00000021, 32'h0, 32'h0, 32'h0000A500, 0, 1, 0, 0, 1);
        checkOutput("lbu_early_ok", ReadDataM, 32'h000000A5);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned lw and sh raise address errors and never reach the bus.
        MemReadM = 1'b1;
        MemSizeM = 2'b10;
        ALUOutM  = 32'h00000102;
        expAdEL  = 1'b1;
        expBad   = 32'h00000102;
        nextCycle();
        MemReadM  = 1'b0;
        MemWriteM = 1'b1;
        MemSizeM  = 2'b01;
        ALUOutM   = 32'h00000101;
        expAdEL   = 1'b0;
        expAdES   = 1'b1;
        expBad    = 32'h00000101;
        nextCycle();
        idleInputs();
        expAdES = 1'b0;
        expBad  = 32'h0;
        nextCycle();
`else
        // Without the check the misaligned lw is issued and returns the whole word.
        applyStimulus(1, 2'b10, 0, 32'h00000102, 32'h0, 32'h0, 32'h13579BDF, 0, 0, 0, 0, 0);
        checkOutput("misaligned_lw", ReadDataM, 32'h13579BDF);
`endif

        // Reset in WAIT: back to IDLE with a cleared result.
        MemReadM     = 1'b1;
        MemSizeM     = 2'b10;
        ALUOutM      = 32'h00000040;
        data_addr_ok = 1'b1;
        expReq       = 1'b1;
        expStall     = 1'b1;
        nextCycle();
        data_addr_ok = 1'b0;
        reset        = 1'b1;
        expReq       = 1'b0;
        expStall     = 1'b0;
        nextCycle();
        reset   = 1'b0;
        idleInputs();
        expRead = 32'h0;
        nextCycle();
        checkOutput("reset_clears", ReadDataM, 32'h0);

        // A normal transaction still works after the mid-flight reset.
        applyStimulus(1, 2'b10, 0, 32'h00000044, 32'h0, 32'h0, 32'h0BADF00D, 2, 0, 0, 0, 0);
        checkOutput("post_reset_lw", ReadDataM, 32'h0BADF00D);

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the pipelined MIPS core. Sits between the EX/MEM pipeline register and the MEM/WB register. Turns the M-stage load/store controls into one transaction on the SRAM-like data interface (req / addr_ok / data_ok) toward the AXI bridge. It stalls the pipeline until the transaction completes and delivers the aligned, extended load result as ReadDataM.

## Interface
Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data word width (fixed at 32; byte-lane logic assumes it)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- MemReadM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- MemSizeM  in  2  00 byte, 01 half, 10 word (11 reserved, treated as word)
- MemSignedM  in  1  sign-extend load result
- ALUOutM  in  32  effective address
- WriteDataM  in  32  raw store data (register value)
- FlushM  in  1  kill the M-stage instruction
- StallM  in  1  hazard unit holds M stage for a reason other than this block
- data_req  out  1  request valid
- data_wr  out  1  1 store, 0 load
- data_size  out  2  equals MemSizeM encoding
- data_addr  out  32  request address
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data / write ack valid
- data_rdata  in  32  read data
- ReadDataM  out  32  extended load result, registered
- MemStallM  out  1  stall request to hazard unit
- AdELM, AdESM  out  1  load / store address error (see Configuration)
- BadVAddrM  out  32  faulting address

## Operation
- access = (MemReadM | MemWriteM) & ~FlushM & ~addr_err.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: data_req = access, driven combinationally from the M inputs. These inputs are stable because MemStallM holds the stage.
  - access & addr_ok → WAIT.
  - access & ~addr_ok → REQ, latching addr, wr, size and wdata.
- REQ: data_req=1 from the latched copies. On addr_ok → WAIT.
- WAIT: data_req=0. On data_ok → DONE, capturing the extracted load result into ReadDataM. Stores capture nothing.
- DONE: holds ReadDataM. If StallM=1, stay in DONE, so no duplicate access is issued. If StallM=0 → IDLE.
- MemStallM = (IDLE & access) | REQ | WAIT. It is 0 in DONE.
- Store data lanes:
  - sb → {4{WriteDataM[7:0]}}
  - sh → {2{WriteDataM[15:0]}}
  - sw → WriteDataM
- Load extraction uses byte offset a=addr[1:0]:
  - byte: rdata[8a+7:8a]
  - half: rdata[16*a[1]+15:16*a[1]]
  - The selected field is sign- or zero-extended per MemSignedM.
- Flush in REQ or WAIT: an issued request cannot be withdrawn.
  - Set a kill flag; the transaction completes normally.
  - On data_ok, discard the result (ReadDataM unchanged) and go → IDLE, not DONE.
  - MemStallM remains 1 until data_ok, so no new access overlaps the drain.
- Flush in DONE: → IDLE.

## Timing
- Reset values: state IDLE, ReadDataM 0, kill flag 0, latched request regs 0.
- Outputs while in reset: data_req 0, MemStallM 0, AdELM/AdESM 0, BadVAddrM 0.
- Best case with addr_ok in cycle 0 and data_ok in cycle 1:
  - MemStallM high in cycles 0–1.
  - ReadDataM valid and MemStallM low in cycle 2.
- Each cycle without addr_ok or data_ok adds one stall cycle.
- data_ok arriving in the same cycle as addr_ok is ignored. data_ok is honoured only in WAIT.
- Reset mid-transaction returns to IDLE at once. Bridge-side cleanup is the bridge's responsibility; it is reset by the same signal.
- At most one outstanding transaction.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - addr_err = (half & addr[0]) | (word & addr[1:0]≠0).
  - AdELM = addr_err & MemReadM; AdESM = addr_err & MemWriteM. Both combinational.
  - BadVAddrM = ALUOutM when addr_err, else 0.
  - No request is issued and MemStallM=0 for that instruction.
- MEM_ALIGN_CHECK_EN undefined:
  - addr_err=0; AdELM, AdESM and BadVAddrM are tied 0.
  - Misaligned accesses are issued as-is; the bridge ignores the low bits.

## Structure
- Package mem_defs holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD
  - FSM state encoding
  - DATA_W constant
- Sub-module load_store_align (combinational) holds store lane replication and load extraction/extension.
- The FSM, latches and result register stay in the top module.

## Test plan
- lw at 0x00000010, addr_ok in cycle 0, data_rdata=0x8899AABB on data_ok in cycle 1 → ReadDataM=0x8899AABB in cycle 2; MemStallM high exactly 2 cycles.
- lb at 0x...13 with MemSignedM=1 and rdata 0x80112233 → 0xFFFFFF80. lhu at 0x...12, same data → 0x00008011.
- sh of 0x1234ABCD at 0x...02, addr_ok delayed 3 cycles → data_req held 4 cycles with data_wdata=0xABCDABCD, data_wr=1, data_size=01 stable throughout.
- FlushM asserted in WAIT → data_ok consumed, ReadDataM unchanged, state IDLE, MemStallM low the cycle after data_ok.
- DONE with StallM high for 3 cycles → no second data_req; ReadDataM stable.
- With MEM_ALIGN_CHECK_EN: lw at 0x...02 → AdELM=1, BadVAddrM=0x...02, data_req 0, MemStallM 0. Without the macro: request issued normally.
